cpu_in_scheduler: RTL and testbench

Time-multiplexes the CPU's single 8-bit input port between several requesters. Each granted requester's byte is driven onto the CPU input for a fixed number of cycles, long enough for the CPU's polling loop to see it. The CPU output byte is then sampled and returned to that requester. The block sits between the CPU core and its input sources and owns the CPU input port exclusively.

---
 rtl/cpu_sched_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/cpu_in_scheduler.sv | 141 ++++++++++++++
 tb/tb_cpu_in_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sched_pkg.sv
// Shared definitions for the CPU input scheduler and the CPU benches.
//   sched_state_e   : IDLE / DRIVE / GAP state encoding (2 bits)
//   HOLD_CYCLES_DEF : default number of cycles a byte is held on cpu_in
//   IDLE_VALUE_DEF  : default value driven on cpu_in between transactions
//   clog2, max3     : elaboration-time sizing helpers
package cpu_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_e;

    localparam int unsigned HOLD_CYCLES_DEF = 70;
    localparam int unsigned IDLE_VALUE_DEF  = 0;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req  : request vector
//   ptr  : index searched first; search wraps ptr, ptr+1, ... mod N
//   en   : qualifies the whole search
//   pick : one-hot winner
//   idx  : binary index of the winner
//   any  : a winner exists
module rr_arbiter
    import cpu_sched_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]                         req,
    input  logic [clog2(max3(N, 2, 1))-1:0]      ptr,
    input  logic                                 en,
    output logic [N-1:0]                         pick,
    output logic [clog2(max3(N, 2, 1))-1:0]      idx,
    output logic                                 any
);

    localparam int unsigned IDX_W = clog2(max3(N, 2, 1));

    logic        w_found;
    int unsigned w_j;

    // First requester at or after ptr, in wrap-around order.
    always_comb begin
        pick    = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_j = (32'(ptr) + k) % N;
            if (en && !w_found && req[w_j]) begin
                w_found    = 1'b1;
                pick[w_j]  = 1'b1;
                idx        = IDX_W'(w_j);
            end
        end
        any = w_found;
    end

endmodule

// File: rtl/cpu_in_scheduler.sv
// Time-multiplexes the CPU's single input port between N_REQ requesters.
// A granted byte is held on cpu_in for HOLD_CYCLES cycles, cpu_out is then
// sampled and returned to that requester, followed by GAP_CYCLES of IDLE_VALUE.
//   clk, rst   : clock, synchronous active-high reset
//   req        : level requests, one bit per requester
//   req_data   : requester i's byte at [i*DATA_W +: DATA_W]
//   grant      : one-hot pulse when a request is accepted
//   resp_valid : one-hot pulse when resp_data holds that requester's answer
//   resp_data  : sampled cpu_out
//   busy       : high whenever a transaction or gap is in progress
//   cpu_in     : drives the CPU input port
//   cpu_out    : CPU output port
module cpu_in_scheduler
    import cpu_sched_pkg::*;
#(
    parameter int unsigned        N_REQ       = 4,
    parameter int unsigned        DATA_W      = 8,
    parameter int unsigned        HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned        GAP_CYCLES  = 4,
    parameter logic [DATA_W-1:0]  IDLE_VALUE  = DATA_W'(IDLE_VALUE_DEF)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      busy,
    output logic [DATA_W-1:0]         cpu_in,
    input  logic [DATA_W-1:0]         cpu_out
);

    localparam int unsigned CNT_W = clog2(max3(HOLD_CYCLES, GAP_CYCLES, 2));
    localparam int unsigned IDX_W = clog2(max3(N_REQ, 2, 1));
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  =
        CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    sched_state_e        r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_ptr;
    logic [N_REQ-1:0]    r_sel;
    logic [N_REQ-1:0]    r_grant;
    logic [N_REQ-1:0]    r_resp_valid;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_busy;
    logic [DATA_W-1:0]   r_cpu_in;

    logic [N_REQ-1:0]    w_pick;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic [IDX_W-1:0]    w_ptr_next;
    logic [DATA_W-1:0]   w_sel_data;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req  (req),
        .ptr  (r_ptr),
        .en   (r_state == ST_IDLE),
        .pick (w_pick),
        .idx  (w_idx),
        .any  (w_any)
    );

    assign w_ptr_next = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);

    // Byte of the requester being granted this cycle.
    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_sel        <= '0;
            r_grant      <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_busy       <= 1'b0;
            r_cpu_in     <= IDLE_VALUE;
        end else begin
            r_grant      <= '0;
            r_resp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_pick;
                        r_sel    <= w_pick;
                        r_cpu_in <= w_sel_data;
                        r_cnt    <= HOLD_LOAD;
                        r_ptr    <= w_ptr_next;
                        r_busy   <= 1'b1;
                        r_state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_resp_data  <= cpu_out;
                        r_resp_valid <= r_sel;
                        r_cpu_in     <= IDLE_VALUE;
                        if (GAP_CYCLES == 0) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= GAP_LOAD;
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign busy       = r_busy;
    assign cpu_in     = r_cpu_in;

endmodule

// File: tb/tb_cpu_in_scheduler.sv
module tb_cpu_in_scheduler;

    localparam int unsigned HOLD = 70;
    localparam int unsigned GAP  = 4;

    logic        clk;
    logic        rst;

    // Default-parameter instance
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  resp_valid;
    logic [7:0]  resp_data;
    logic        busy;
    logic [7:0]  cpu_in;
    logic [7:0]  cpu_out;

    // HOLD=1, GAP=0 instance
    logic [3:0]  e_req;
    logic [31:0] e_req_data;
    logic [3:0]  e_grant;
    logic [3:0]  e_resp_valid;
    logic [7:0]  e_resp_data;
    logic        e_busy;
    logic [7:0]  e_cpu_in;
    logic [7:0]  e_cpu_out;

    // The CPU model simply echoes its input.
    assign cpu_out   = cpu_in;
    assign e_cpu_out = e_cpu_in;

    cpu_in_scheduler #(
        .N_REQ(4), .DATA_W(8), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .IDLE_VALUE(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .grant(grant), .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy), .cpu_in(cpu_in), .cpu_out(cpu_out)
    );

    cpu_in_scheduler #(
        .N_REQ(4), .DATA_W(8), .HOLD_CYCLES(1), .GAP_CYCLES(0), .IDLE_VALUE(8'h00)
    ) dut_e (
        .clk(clk), .rst(rst), .req(e_req), .req_data(e_req_data),
        .grant(e_grant), .resp_valid(e_resp_valid), .resp_data(e_resp_data),
        .busy(e_busy), .cpu_in(e_cpu_in), .cpu_out(e_cpu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_grant_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: {resp_valid, resp_data} expected from the default instance.
    logic [11:0] sb_q[$];

    always @(negedge clk) begin
        if (!rst && resp_valid !== 4'b0000) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", {20'h0, resp_valid, resp_data}, 32'h0);
            end else begin
                check("resp", {20'h0, resp_valid, resp_data}, {20'h0, sb_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  req_after;
        logic [31:0] data_after;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_byte;
        bit          chk_period;
    } vec_t;

    // One full transaction: grant, hold, sample, gap, return to IDLE.
    // Enters and leaves on a negedge; returns on the first IDLE cycle.
    task automatic run_vec(input string name, input vec_t v);
        logic hold_bad;
        logic gap_bad;
        req      = v.req;
        req_data = v.data;
        @(negedge clk);
        check({name, "_grant"}, {28'h0, grant}, {28'h0, v.exp_grant});
        check({name, "_busy_rise"}, {31'h0, busy}, 32'h1);
        check({name, "_cpu_in"}, {24'h0, cpu_in}, {24'h0, v.exp_byte});
        if (v.chk_period) check({name, "_period"}, cyc - last_grant_cyc, HOLD + GAP + 1);
        last_grant_cyc = cyc;
        sb_q.push_back({v.exp_grant, v.exp_byte});
        req      = v.req_after;
        req_data = v.data_after;
        hold_bad = 1'b0;
        for (int k = 1; k < int'(HOLD); k++) begin
            @(negedge clk);
            if (cpu_in !== v.exp_byte || grant !== 4'b0000 || busy !== 1'b1) hold_bad = 1'b1;
        end
        check({name, "_hold"}, {31'h0, hold_bad}, 32'h0);
        @(negedge clk);
        check({name, "_cpu_in_idle"}, {24'h0, cpu_in}, 32'h0);
        gap_bad = 1'b0;
        for (int k = 1; k < int'(GAP); k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || cpu_in !== 8'h00) gap_bad = 1'b1;
        end
        check({name, "_gap"}, {31'h0, gap_bad}, 32'h0);
        @(negedge clk);
        check({name, "_busy_fall"}, {31'h0, busy}, 32'h0);
    endtask

    vec_t vecs[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Round-robin with all four held, then pointer wrap, single, late change.
        vecs[0] = '{4'hF, 32'h13121110, 4'hF, 32'h13121110, 4'b0001, 8'h10, 1'b0};
        vecs[1] = '{4'hF, 32'h13121110, 4'hF, 32'h13121110, 4'b0010, 8'h11, 1'b1};
        vecs[2] = '{4'hF, 32'h13121110, 4'hF, 32'h13121110, 4'b0100, 8'h12, 1'b1};
        vecs[3] = '{4'hF, 32'h13121110, 4'hF, 32'h13121110, 4'b1000, 8'h13, 1'b1};
        vecs[4] = '{4'hF, 32'h13121110, 4'h0, 32'h13121110, 4'b0001, 8'h10, 1'b1};
        vecs[5] = '{4'h8, 32'h3C000000, 4'h0, 32'h00000000, 4'b1000, 8'h3C, 1'b0};
        vecs[6] = '{4'h9, 32'h3D0000C3, 4'h0, 32'h00000000, 4'b0001, 8'hC3, 1'b0};
        vecs[7] = '{4'h1, 32'h00000001, 4'h0, 32'h00000000, 4'b0001, 8'h01, 1'b0};
        vecs[8] = '{4'h2, 32'h00000200, 4'h0, 32'h00000700, 4'b0010, 8'h02, 1'b0};

        rst = 1'b1;
        req = '0; req_data = '0;
        e_req = '0; e_req_data = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_cpu_in", {24'h0, cpu_in}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_grant", {28'h0, grant}, 32'h0);
        check("reset_resp_data", {24'h0, resp_data}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset mid-DRIVE: pointer is now 2, requester 2 granted then aborted.
        req = 4'b0100; req_data = 32'h00550000;
        @(negedge clk);
        check("abort_grant", {28'h0, grant}, 32'h4);
        req = 4'b0000;
        for (int k = 1; k < 30; k++) @(negedge clk);
        check("abort_cpu_in_before", {24'h0, cpu_in}, 32'h55);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cpu_in", {24'h0, cpu_in}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_resp_data", {24'h0, resp_data}, 32'h0);
        rst = 1'b0;
        repeat (HOLD + GAP + 5) @(negedge clk);
        run_vec("post_reset", '{4'h9, 32'h33000099, 4'h0, 32'h0, 4'b0001, 8'h99, 1'b0});
        repeat (3) @(negedge clk);
        check("sb_drain", sb_q.size(), 32'h0);

        // HOLD=1, GAP=0: sample one cycle after grant, back-to-back period of 2.
        e_req = 4'b0011; e_req_data = 32'h0000B6A5;
        @(negedge clk);
        check("edge_grant0", {28'h0, e_grant}, 32'h1);
        check("edge_cpu_in0", {24'h0, e_cpu_in}, 32'hA5);
        check("edge_busy0", {31'h0, e_busy}, 32'h1);
        check("edge_no_resp0", {28'h0, e_resp_valid}, 32'h0);
        @(negedge clk);
        check("edge_resp_valid0", {28'h0, e_resp_valid}, 32'h1);
        check("edge_resp_data0", {24'h0, e_resp_data}, 32'hA5);
        check("edge_cpu_in_idle0", {24'h0, e_cpu_in}, 32'h0);
        check("edge_busy_fall0", {31'h0, e_busy}, 32'h0);
        @(negedge clk);
        check("edge_grant1", {28'h0, e_grant}, 32'h2);
        check("edge_cpu_in1", {24'h0, e_cpu_in}, 32'hB6);
        e_req = 4'b0000;
        @(negedge clk);
        check("edge_resp_valid1", {28'h0, e_resp_valid}, 32'h2);
        check("edge_resp_data1", {24'h0, e_resp_data}, 32'hB6);
        @(negedge clk);
        check("edge_idle_grant", {28'h0, e_grant}, 32'h0);
        check("edge_idle_busy", {31'h0, e_busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
